// File: rtl/hams_mem_drain_pkg.sv
// hams_pkg: constants and types shared by the HAMS drain path.
//   NUM_ELEMENTS      elements per chunk (one per work BRAM bank)
//   HAMS_RD_LATENCY   work BRAM address-to-data latency (output pipeline on)
//   hams_drain_state_e  drain controller states
package hams_pkg;

  localparam int NUM_ELEMENTS    = 4;
  localparam int HAMS_RD_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hams_drain_state_e;

endpackage

// File: rtl/hams_mem_drain_if.sv
// hams_mem_drain_if: bank read bus plus the serialized element stream.
//   mem_addr   per-bank read address (NUM_MEM x ADDR_WIDTH)
//   mem_rdata  per-bank read data (NUM_MEM x DATA_WIDTH), bank i in slice i
//   out_data / out_valid / out_ready  valid/ready element stream
// master = drain engine, slave = memories plus stream sink.
interface hams_mem_drain_if
  import hams_pkg::*;
#(
  parameter int NUM_MEM    = NUM_ELEMENTS,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
);

  logic [NUM_MEM*ADDR_WIDTH-1:0] mem_addr;
  logic [NUM_MEM*DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0]         out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output mem_addr,
    output out_data,
    output out_valid,
    input  mem_rdata,
    input  out_ready
  );

  modport slave (
    input  mem_addr,
    input  out_data,
    input  out_valid,
    output mem_rdata,
    output out_ready
  );

endinterface

// File: rtl/hams_mem_drain_syncfifo.sv
// hams_syncfifo: single-clock first-word-fall-through FIFO used as the
// chunk buffer of the drain engine.
//   clk, rst_n  clock, asynchronous active-low reset
//   wr_en, wr_data  push (ignored when full)
//   rd_en           pop (ignored when empty)
//   rd_data         current head entry
//   count, empty    occupancy
module hams_syncfifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_WIDTH = 32,
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty
);

  logic [FIFO_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;
  logic                  wr_s;
  logic                  rd_s;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign empty   = (count_r == '0);
  assign wr_s    = wr_en && (count_r != CNT_W'(FIFO_DEPTH));
  assign rd_s    = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r];
  assign count   = count_r;

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (rd_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({wr_s, rd_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed through a valid count
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/hams_mem_drain.sv
// hams_mem_drain: reads sorted chunks out of the NUM_MEM work BRAM banks
// (one address = one chunk, element i in bank i) and serializes them onto a
// single valid/ready stream, element 0..NUM_MEM-1 of chunk 0, then chunk 1...
//   clk, rst_n    clock, asynchronous active-low reset
//   start         begin a drain (sampled only in IDLE)
//   num_chunks    chunks to drain, sampled with start, clamped to MEM_DEPTH
//   unsigned_cmp  order-check compare mode (1 unsigned, 0 signed)
//   bus           hams_mem_drain_if.master: bank address/data, element stream
//   busy          high while the drain is running
//   done          one-cycle pulse after the last element is accepted
//   order_err     sticky in-chunk ordering violation
// Optional feature macro: HAMS_ORDER_CHECK_EN builds the in-chunk order
// checker; without it order_err is tied low.
module hams_mem_drain
  import hams_pkg::*;
#(
  parameter int NUM_MEM    = NUM_ELEMENTS,
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = HAMS_RD_LATENCY,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num_chunks,
  input  logic                  unsigned_cmp,
  hams_mem_drain_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  order_err
);

  localparam int IDX_W  = (NUM_MEM > 1) ? $clog2(NUM_MEM) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int INF_W  = $clog2(RD_LATENCY + 1);
  localparam int FIFO_W = DATA_WIDTH * NUM_MEM;
  localparam logic [ADDR_WIDTH:0] MEM_DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  hams_drain_state_e       state_r;
  hams_drain_state_e       state_next_s;
  logic [ADDR_WIDTH-1:0]   mem_addr_r;
  logic [ADDR_WIDTH-1:0]   last_addr_r;
  logic [RD_LATENCY-1:0]   rd_pipe_r;
  logic [IDX_W-1:0]        idx_r;
  logic [ADDR_WIDTH:0]     chunks_clamped_s;
  logic [INF_W-1:0]        inflight_s;
  logic                    credit_ok_s;
  logic                    issue_s;
  logic                    start_acc_s;
  logic                    push_s;
  logic                    pop_s;
  logic                    accept_s;
  logic [FIFO_W-1:0]       fifo_head_s;
  logic [CNT_W-1:0]        fifo_count_s;
  logic                    fifo_empty_s;
  logic [DATA_WIDTH-1:0]   elem_s [NUM_MEM];
  logic [DATA_WIDTH-1:0]   out_data_s;
  logic                    out_valid_s;
  logic                    busy_s;
  logic                    done_s;

  // Chunk buffer; the credit rule below keeps it from ever overflowing.
  hams_syncfifo #(
    .FIFO_DEPTH (BUF_DEPTH),
    .FIFO_WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push_s),
    .wr_data (bus.mem_rdata),
    .rd_en   (pop_s),
    .rd_data (fifo_head_s),
    .count   (fifo_count_s),
    .empty   (fifo_empty_s)
  );

  assign start_acc_s      = (state_r == IDLE) && start;
  assign chunks_clamped_s = (num_chunks > MEM_DEPTH_C) ? MEM_DEPTH_C : num_chunks;
  assign push_s           = rd_pipe_r[RD_LATENCY-1];
  assign accept_s         = out_valid_s && bus.out_ready;
  assign pop_s            = accept_s && (idx_r == IDX_W'(NUM_MEM - 1));

  // Count reads still travelling through the BRAM pipeline
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + INF_W'(rd_pipe_r[i]);
    end
  end

  // A read may only go out if a buffer slot is guaranteed for its data.
  assign credit_ok_s = (32'(inflight_s) + 32'(fifo_count_s)) < 32'(BUF_DEPTH);
  assign issue_s     = (state_r == RUN) && credit_ok_s;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (num_chunks == '0) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RUN;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (issue_s && (mem_addr_r == last_addr_r)) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        // Leave once nothing is in flight and the final element is taken
        // this cycle, so done lands right after the last handshake.
        if ((rd_pipe_r == '0) &&
            (fifo_empty_s || ((fifo_count_s == CNT_W'(1)) && pop_s))) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Split the buffer head into its per-bank elements
  always_comb begin
    for (int i = 0; i < NUM_MEM; i++) begin
      elem_s[i] = fifo_head_s[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // FSM and stream output decode
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      RUN, DRAIN: busy_s = 1'b1;
      DONE:       done_s = 1'b1;
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
    out_valid_s = !fifo_empty_s;
    if (out_valid_s) begin
      out_data_s = elem_s[idx_r];
    end else begin
      out_data_s = '0;
    end
  end

  // Read address and the last address of the current drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r  <= '0;
      last_addr_r <= '0;
    end else if (start_acc_s) begin
      mem_addr_r  <= '0;
      last_addr_r <= ADDR_WIDTH'(chunks_clamped_s - (ADDR_WIDTH + 1)'(1));
    end else if (issue_s && (mem_addr_r != last_addr_r)) begin
      mem_addr_r  <= mem_addr_r + ADDR_WIDTH'(1);
    end else begin
      mem_addr_r  <= mem_addr_r;
    end
  end

  // In-flight read tracker; its tail marks mem_rdata as valid to push
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe_r <= '0;
    end else begin
      rd_pipe_r[0] <= issue_s;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_pipe_r[i] <= rd_pipe_r[i-1];
      end
    end
  end

  // Element index over the buffer head
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r <= '0;
    end else if (start_acc_s) begin
      idx_r <= '0;
    end else if (accept_s) begin
      if (idx_r == IDX_W'(NUM_MEM - 1)) begin
        idx_r <= '0;
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      idx_r <= idx_r;
    end
  end

`ifdef HAMS_ORDER_CHECK_EN
  logic [DATA_WIDTH-1:0] prev_r;
  logic                  order_err_r;
  logic                  viol_s;

  function automatic logic elem_gt(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input logic                  uns);
    if (uns) begin
      return a > b;
    end else begin
      return $signed(a) > $signed(b);
    end
  endfunction

  // Element 0 of each chunk is never compared: chunk boundaries are free.
  assign viol_s = accept_s && (idx_r != '0) && elem_gt(prev_r, out_data_s, unsigned_cmp);

  // Previous accepted element and the sticky violation flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r      <= '0;
      order_err_r <= 1'b0;
    end else begin
      if (accept_s) begin
        prev_r <= out_data_s;
      end
      if (start_acc_s) begin
        order_err_r <= 1'b0;
      end else if (viol_s) begin
        order_err_r <= 1'b1;
      end
    end
  end

  assign order_err = order_err_r;
`else
  logic cmp_mode_unused_s;
  assign cmp_mode_unused_s = unsigned_cmp;
  assign order_err         = 1'b0;
`endif

  assign bus.mem_addr  = {NUM_MEM{mem_addr_r}};
  assign bus.out_data  = out_data_s;
  assign bus.out_valid = out_valid_s;
  assign busy          = busy_s;
  assign done          = done_s;

endmodule

// File: tb/tb_hams_mem_drain.sv
// Self-checking bench for hams_mem_drain (NUM_MEM=4, MEM_DEPTH=16).
module tb_hams_mem_drain;

  localparam int NM    = 4;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int BUFD  = 4;
`ifdef HAMS_ORDER_CHECK_EN
  localparam bit ORDER_ON = 1'b1;
`else
  localparam bit ORDER_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   num_chunks = '0;
  logic          unsigned_cmp = 1'b1;
  logic          busy, done, order_err;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] bank [NM][DEPTH];
  logic [DW-1:0] rd1 [NM];
  logic [DW-1:0] rd2 [NM];

  always #5 clk = ~clk;

  hams_mem_drain_if #(.NUM_MEM(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  hams_mem_drain #(
    .NUM_MEM(NM), .MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .RD_LATENCY(2), .BUF_DEPTH(BUFD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_chunks(num_chunks),
    .unsigned_cmp(unsigned_cmp), .bus(bus), .busy(busy), .done(done),
    .order_err(order_err)
  );

  // Two-stage BRAM read model: address in cycle c, data in cycle c+2.
  always @(posedge clk) begin
    for (int b = 0; b < NM; b++) begin
      rd1[b] <= bank[b][bus.mem_addr[b*AW +: AW]];
      rd2[b] <= rd1[b];
    end
  end
  assign bus.mem_rdata = {rd2[3], rd2[2], rd2[1], rd2[0]};

  task automatic fill_linear();
    for (int c = 0; c < DEPTH; c++)
      for (int b = 0; b < NM; b++) bank[b][c] = 32'(c * NM + b + 1);
  endtask

  task automatic push_range(input int first, input int last);
    exp_q.delete();
    for (int v = first; v <= last; v++) exp_q.push_back(32'(v));
  endtask

  // Returns at the falling edge of cycle 1 (start sampled at the edge before).
  task automatic kick(input logic [AW:0] n);
    @(negedge clk); start = 1'b1; num_chunks = n;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic test_reset();
    bus.out_ready = 1'b0;
    fill_linear();
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.out_valid, busy, done, order_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b busy=%b done=%b err=%b, want 0", bus.out_valid, busy, done, order_err);
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h data=%h, want 0", bus.mem_addr, bus.out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b valid=%b, want 0", busy, bus.out_valid);
    end
  endtask

  task automatic test_basic();
    int cyc = 1, n_out = 0, n_done = 0, first_v = 0, last_acc = 0;
    logic [DW-1:0] e;
    fill_linear(); push_range(1, 8);
    bus.out_ready = 1'b1; unsigned_cmp = 1'b1;
    kick(5'd2);
    checks++;
    if (bus.mem_addr !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_c1: addr=%h busy=%b, want 0/1", bus.mem_addr, busy);
    end
    while (cyc < 60 && n_done == 0) begin
      if (bus.out_valid && first_v == 0) first_v = cyc;
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (bus.out_data !== e || cyc != 4 + n_out) begin
          errors++;
          $display("FAIL basic_elem: data=%0d cyc=%0d, want %0d at cyc %0d", bus.out_data, cyc, e, 4 + n_out);
        end
        n_out++; last_acc = cyc;
      end
      if (done) begin
        n_done++;
        checks++;
        if (cyc != last_acc + 1 || busy !== 1'b0 || order_err !== 1'b0) begin
          errors++;
          $display("FAIL basic_done: cyc=%0d busy=%b err=%b, want cyc %0d busy 0 err 0", cyc, busy, order_err, last_acc + 1);
        end
      end
      @(negedge clk); cyc++;
    end
    checks++;
    if (first_v != 4 || n_out != 8 || n_done != 1) begin
      errors++;
      $display("FAIL basic_totals: first_valid=%0d n=%0d done=%0d, want 4/8/1", first_v, n_out, n_done);
    end
  endtask

  task automatic test_backpressure();
    int cyc = 1, n_out = 0, n_done = 0;
    bit prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0, e;
    fill_linear(); push_range(1, 64);
    kick(5'd16);
    while (cyc < 400 && n_done == 0) begin
      bus.out_ready = (cyc % 2) == 1;
      if (prev_stall) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data) begin
          errors++;
          $display("FAIL bp_stable: valid=%b data=%0d, want 1/%0d", bus.out_valid, bus.out_data, prev_data);
        end
      end
      checks++;
      if (dut.fifo_count_s > BUFD) begin
        errors++;
        $display("FAIL bp_buffer: count=%0d, want <= %0d", dut.fifo_count_s, BUFD);
      end
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL bp_elem: data=%0d, want %0d", bus.out_data, e);
        end
        n_out++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      if (done) n_done++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (n_out != 64 || n_done != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_totals: n=%0d done=%0d left=%0d, want 64/1/0", n_out, n_done, exp_q.size());
    end
  endtask

  task automatic test_clamp();
    int cyc = 1, n_out = 0, n_done = 0, max_addr = 0;
    logic [DW-1:0] e;
    fill_linear(); push_range(1, 64);
    bus.out_ready = 1'b1;
    kick(5'd20);
    while (cyc < 200 && n_done == 0) begin
      if (int'(bus.mem_addr[AW-1:0]) > max_addr) max_addr = int'(bus.mem_addr[AW-1:0]);
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL clamp_elem: data=%0d, want %0d", bus.out_data, e);
        end
        n_out++;
      end
      if (done) n_done++;
      @(negedge clk); cyc++;
    end
    checks++;
    if (n_out != 64 || n_done != 1 || max_addr != 15) begin
      errors++;
      $display("FAIL clamp_totals: n=%0d done=%0d max_addr=%0d, want 64/1/15", n_out, n_done, max_addr);
    end
  endtask

  task automatic test_zero();
    int n_done = 0;
    bus.out_ready = 1'b1;
    kick(5'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done: done=%b busy=%b, want 1/0", done, busy);
    end
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (done) n_done++;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.mem_addr !== '0) begin
        errors++;
        $display("FAIL zero_quiet: cyc=%0d valid=%b addr=%h, want 0/0", cyc, bus.out_valid, bus.mem_addr);
      end
      @(negedge clk);
    end
    checks++;
    if (n_done != 1) begin
      errors++;
      $display("FAIL zero_pulses: done pulses=%0d, want 1", n_done);
    end
  endtask

  task automatic test_order();
    int n_out = 0;
    logic [DW-1:0] e;
    logic [DW-1:0] neg [4];
    bit exp_err;
    // Chunk 4,2,7,9 unsigned: the 4 > 2 step is flagged.
    bank[0][0] = 32'd4; bank[1][0] = 32'd2; bank[2][0] = 32'd7; bank[3][0] = 32'd9;
    exp_q.delete();
    exp_q.push_back(32'd4); exp_q.push_back(32'd2); exp_q.push_back(32'd7); exp_q.push_back(32'd9);
    bus.out_ready = 1'b1; unsigned_cmp = 1'b1;
    kick(5'd1);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      exp_err = ORDER_ON && (cyc >= 6);
      checks++;
      if (order_err !== exp_err) begin
        errors++;
        $display("FAIL order_rise: cyc=%0d err=%b, want %b", cyc, order_err, exp_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL order_elem: data=%0d, want %0d", bus.out_data, e);
        end
        n_out++;
      end
      @(negedge clk);
    end
    // Signed chunk -5,-3,0,1 after an ascending chunk: no error, boundary free.
    neg[0] = 32'hFFFF_FFFB; neg[1] = 32'hFFFF_FFFD; neg[2] = 32'd0; neg[3] = 32'd1;
    exp_q.delete();
    for (int b = 0; b < NM; b++) begin
      bank[b][0] = 32'(b + 1); bank[b][1] = neg[b];
    end
    for (int b = 0; b < NM; b++) exp_q.push_back(32'(b + 1));
    for (int b = 0; b < NM; b++) exp_q.push_back(neg[b]);
    unsigned_cmp = 1'b0;
    kick(5'd2);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      checks++;
      if (order_err !== 1'b0) begin
        errors++;
        $display("FAIL order_signed: cyc=%0d err=%b, want 0", cyc, order_err);
      end
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL order_selem: data=%h, want %h", bus.out_data, e);
        end
        n_out++;
      end
      @(negedge clk);
    end
    checks++;
    if (n_out != 12) begin
      errors++;
      $display("FAIL order_count: n=%0d, want 12", n_out);
    end
    unsigned_cmp = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n_out = 0, n_done = 0;
    logic [DW-1:0] e;
    fill_linear();
    bus.out_ready = 1'b0;
    kick(5'd4);
    repeat (2) @(negedge clk);
    checks++;
    if (dut.rd_pipe_r !== 2'b11 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rmid_pre: inflight=%b busy=%b, want 11/1", dut.rd_pipe_r, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, busy, done, order_err} !== 4'b0000 || bus.mem_addr !== '0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL rmid_reset: valid=%b busy=%b done=%b err=%b addr=%h data=%h, want 0", bus.out_valid, busy, done, order_err, bus.mem_addr, bus.out_data);
    end
    @(negedge clk); rst_n = 1'b1;
    push_range(1, 4);
    bus.out_ready = 1'b1;
    kick(5'd1);
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL rmid_elem: data=%0d, want %0d", bus.out_data, e);
        end
        n_out++;
      end
      if (done) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_out != 4 || n_done != 1) begin
      errors++;
      $display("FAIL rmid_totals: n=%0d done=%0d, want 4/1", n_out, n_done);
    end
  endtask

  task automatic test_start_busy();
    int n_out = 0, n_done = 0;
    logic [DW-1:0] e;
    fill_linear(); push_range(1, 16);
    bus.out_ready = 1'b1;
    kick(5'd4);
    for (int cyc = 1; cyc <= 30; cyc++) begin
      if (cyc == 10) begin start = 1'b1; num_chunks = 5'd2; end
      if (cyc == 11) start = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++;
        if (bus.out_data !== e) begin
          errors++;
          $display("FAIL sbusy_elem: data=%0d, want %0d", bus.out_data, e);
        end
        n_out++;
      end
      if (done) n_done++;
      @(negedge clk);
    end
    checks++;
    if (n_out != 16 || n_done != 1) begin
      errors++;
      $display("FAIL sbusy_totals: n=%0d done=%0d, want 16/1", n_out, n_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_clamp();
    test_zero();
    test_order();
    test_reset_mid();
    test_start_busy();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
